// File: rtl/if_fetch.sv
// if_fetch: fetches 32-bit instructions as four byte reads and presents {pc, inst} with valid, stall hold and branch redirect
module if_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  stall_in,
  input  logic                  branch_taken_in,
  input  logic [ADDR_WIDTH-1:0] branch_target_in,
  input  logic                  mem_grant_in,
  input  logic [7:0]            mem_data_in,
  output logic                  mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [31:0]           inst_out,
  output logic                  inst_valid_out
);
  localparam logic [2:0] S0     = 3'd0;
  localparam logic [2:0] S4     = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           inst_q, inst_d;
  logic                  valid_q, valid_d;
  logic                  pend_q, pend_d;
  logic [1:0]            pidx_q, pidx_d;
  logic [31:0]           buf_q, buf_d;
  logic                  issue;
  // read issue is combinational; held off during reset and in a redirect cycle
  always_comb begin
    issue         = rst_in && !branch_taken_in && !state_q[2] && mem_grant_in;
    mem_rd_en_out = issue;
    mem_addr_out  = issue ? fetch_pc_q + ADDR_WIDTH'(state_q[1:0]) : '0;
  end
  // next state: redirect beats everything, then issue, final-byte assembly, accept
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    pend_d     = issue;
    pidx_d     = issue ? state_q[1:0] : pidx_q;
    buf_d      = buf_q;
    if (pend_q) buf_d[8*pidx_q +: 8] = mem_data_in;
    if (branch_taken_in) begin
      fetch_pc_d = branch_target_in & ~ADDR_WIDTH'(3);
      state_d    = S0;
      valid_d    = 1'b0;
      pend_d     = 1'b0;
      buf_d      = buf_q;
    end else if (issue) begin
      state_d = state_q + 3'd1;
    end else if (state_q == S4 && pend_q) begin
      state_d = S_DONE;
      pc_d    = fetch_pc_q;
      inst_d  = {mem_data_in, buf_q[23:0]};
      valid_d = 1'b1;
    end else if (state_q == S_DONE && !stall_in) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      state_d    = S0;
      valid_d    = 1'b0;
    end
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S0;
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      pidx_q     <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      pidx_q     <= pidx_d;
      buf_q      <= buf_d;
    end
  end
  assign pc_out         = pc_q;
  assign inst_out       = inst_q;
  assign inst_valid_out = valid_q;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed and random checks of if_fetch against a read-counting reference model
module tb_if_fetch;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic [31:0] branch_target_in = '0;
  logic        mem_grant_in = 1'b0;
  logic [7:0]  mem_data_in = '0;
  logic        mem_rd_en_out;
  logic [31:0] mem_addr_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid_out;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc;
  int          nreads;
  logic        exp_valid;
  logic [31:0] exp_pcout;
  logic [31:0] exp_inst;

  if_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
    .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
    .mem_grant_in(mem_grant_in), .mem_data_in(mem_data_in),
    .mem_rd_en_out(mem_rd_en_out), .mem_addr_out(mem_addr_out),
    .pc_out(pc_out), .inst_out(inst_out), .inst_valid_out(inst_valid_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'd37) ^ (a >> 11) ^ (a >> 24) ^ 32'h5A;
    return a == 32'd0 ? 8'h13 : a == 32'd1 ? 8'h05 : a == 32'd2 ? 8'h10 : a == 32'd3 ? 8'h00 : h[7:0];
  endfunction

  function automatic logic [31:0] word(input logic [31:0] p);
    return {ram(p + 32'd3), ram(p + 32'd2), ram(p + 32'd1), ram(p)};
  endfunction

  // RAM answers one cycle after an issued read; otherwise the bus carries junk
  always @(posedge clk_in) mem_data_in <= mem_rd_en_out ? ram(mem_addr_out) : 8'($urandom);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_pc = 32'h0;
    nreads = 0;
    exp_valid = 1'b0;
  endtask

  // one clock cycle, entered and left at a falling edge
  task automatic cyc(input logic st, input logic gr, input logic br, input logic [31:0] tgt);
    logic exp_rd;
    stall_in = st;
    mem_grant_in = gr;
    branch_taken_in = br;
    branch_target_in = tgt;
    #1;
    exp_rd = !br && gr && nreads < 4;
    chk("rd_en", 32'(mem_rd_en_out), 32'(exp_rd));
    if (exp_rd) chk("addr", mem_addr_out, exp_pc + 32'(nreads));
    @(posedge clk_in);
    if (br) begin
      exp_pc = tgt & ~32'd3;
      nreads = 0;
      exp_valid = 1'b0;
    end else if (exp_rd) begin
      nreads++;
    end else if (nreads == 4 && !exp_valid) begin
      exp_valid = 1'b1;
      exp_pcout = exp_pc;
      exp_inst = word(exp_pc);
    end else if (exp_valid && !st) begin
      exp_pc = exp_pc + 32'd4;
      nreads = 0;
      exp_valid = 1'b0;
    end
    @(negedge clk_in);
    chk("valid", 32'(inst_valid_out), 32'(exp_valid));
    if (exp_valid) begin
      chk("pc_out", pc_out, exp_pcout);
      chk("inst_out", inst_out, exp_inst);
    end
  endtask

  initial begin
    model_reset();
    mem_grant_in = 1'b1;
    #2;
    chk("rst_rd_en", 32'(mem_rd_en_out), 32'd0);
    chk("rst_addr", mem_addr_out, 32'd0);
    chk("rst_valid", 32'(inst_valid_out), 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("t1_inst", inst_out, 32'h00100513);
    chk("t1_pc", pc_out, 32'd0);
    chk("t1_valid", 32'(inst_valid_out), 32'd1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("t2_hold_inst", inst_out, 32'h00100513);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("t3_pc", pc_out, 32'd4);
    chk("t3_inst", inst_out, word(32'd4));
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 32'h103);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("t4_pc", pc_out, 32'h100);
    chk("t4_inst", inst_out, word(32'h100));
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("t5_pc", pc_out, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    #1;
    chk("t5_wrap_addr", mem_addr_out, 32'd0);
    @(negedge clk_in);
    model_reset();
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (7) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("t6_pre_valid", 32'(inst_valid_out), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    #2;
    rst_in = 1'b0;
    #1;
    chk("t6_rd_en", 32'(mem_rd_en_out), 32'd0);
    chk("t6_valid", 32'(inst_valid_out), 32'd0);
    chk("t6_pc", pc_out, 32'd0);
    chk("t6_inst", inst_out, 32'd0);
    @(negedge clk_in);
    model_reset();
    rst_in = 1'b1;
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("t6_restart_inst", inst_out, 32'h00100513);
    repeat (400) cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 15) == 0), $urandom);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
